memory_game_core: RTL and testbench
===================================

Name: memory_game_core

Overview:
Parametrised next-generation game engine for the memory-tester. It generates a pseudo-random digit sequence, flashes it one digit at a time, then collects the player's answers (toggle switches plus punch button) with a per-answer timeout. It reports win or lose, tracks level and score, and sits between the authentication/button-debounce logic and the seven-segment/LED display drivers.

Parameters:
DIGIT_W, 4, width of each sequence digit and of toggle_answer.
MAX_LEN, 8, maximum sequence length (final level); minimum 2.
FLASH_CYCLES, 50000000, cycles each digit is shown.
GAP_CYCLES, 12500000, blank cycles after each flashed digit.
ANSWER_TIMEOUT, 250000000, cycles allowed per answer before a timeout lose.
LFSR_SEED, 16'hACE1, LFSR reset value; must be non-zero.

Ports:
clock  in  1  system clock, single clock domain.
rst  in  1  asynchronous, active-low reset.
auth_bit  in  1  player authenticated; start_pulse ignored while low.
logout  in  1  synchronous abort to IDLE, highest priority after rst.
start_pulse  in  1  one-cycle pulse: start/continue a round.
punch_button  in  1  one-cycle pulse: submit toggle_answer.
toggle_answer  in  DIGIT_W  player answer digit.
flash_num  out  DIGIT_W  digit being flashed; 0 when flash_valid=0.
flash_valid  out  1  high while a digit is displayed.
seg_in_ans  out  DIGIT_W  last submitted answer (display echo).
answer_idx  out  $clog2(MAX_LEN)  index of the next expected answer.
level  out  $clog2(MAX_LEN+1)  current sequence length, 1..MAX_LEN.
score  out  8  rounds won since login, saturating at 255.
win  out  1  round won, held until next start_pulse or logout.
loose  out  1  round lost, held until next start_pulse or logout.
game_done  out  1  final level (MAX_LEN) won.
busy  out  1  high in every state except IDLE, WIN and LOSE.

Behaviour:
- Reset values: all outputs 0 except level=1; FSM=IDLE; LFSR=LFSR_SEED; sequence RAM cleared.
- LFSR: 16-bit Fibonacci, taps 16,14,13,11. It advances every clock from reset, unconditionally.
- FSM states: IDLE, GEN, FLASH, GAP, INPUT, WIN, LOSE.
- IDLE, WIN or LOSE + start_pulse + auth_bit:
  - go to GEN; clear win, loose, answer_idx and seg_in_ans.
  - If game_done=1, first reset level to 1 and clear game_done.
  - start_pulse with auth_bit=0 is ignored.
- GEN: writes seq[i] = lfsr[DIGIT_W-1:0] for i = 0..level-1, one digit per cycle using the current LFSR value. It takes exactly `level` cycles, then goes to FLASH with i=0.
- FLASH: flash_valid=1 and flash_num=seq[i] for exactly FLASH_CYCLES cycles, then GAP.
- GAP: flash_valid=0 for GAP_CYCLES cycles.
  - Then, if i<level-1: i++ and return to FLASH.
  - Otherwise go to INPUT with answer_idx=0 and the timeout counter cleared.
- INPUT, on punch_button:
  - seg_in_ans <= toggle_answer and the timeout counter restarts.
  - Mismatch with seq[answer_idx]: go to LOSE.
  - Match and answer_idx==level-1: go to WIN.
  - Match otherwise: answer_idx++.
- INPUT, timeout: if the counter reaches ANSWER_TIMEOUT-1 without a punch, go to LOSE.
  - If a punch and timeout expiry coincide, the punch is evaluated and the timeout is ignored.
- WIN (entry cycle): win=1; score+1, saturating; if level<MAX_LEN then level+1, else game_done=1 and level is held.
- LOSE (entry cycle): loose=1; level unchanged (retry same length).
- Punch outside INPUT is ignored, and seg_in_ans is unchanged.
- start_pulse while busy is ignored.
- logout (synchronous, any state):
  - FSM goes to IDLE; level=1; score=0.
  - win, loose, game_done, flash_valid, flash_num, seg_in_ans and answer_idx are all cleared.
  - LFSR keeps running.
- rst asserted mid-round: immediate return to reset values, regardless of state.
- win and loose are mutually exclusive, never both 1.
- Latency: win or loose asserts on the clock edge following the deciding punch or timeout.

Test Plan:
Use DIGIT_W=4, MAX_LEN=4, FLASH_CYCLES=4, GAP_CYCLES=2, ANSWER_TIMEOUT=10, with a bench LFSR model.
1. Reset, then auth_bit=1 and start_pulse -> GEN takes 1 cycle; flash_valid high 4 cycles with flash_num=model digit, then low 2 cycles; busy=1 throughout.
2. Correct answers through level 1→4 (each start after win) -> win each round, level 2,3,4 after rounds 1..3, score=4, game_done=1 after the 4th win, level stays 4.
3. Level 3 round with the second answer wrong -> loose=1 on the next edge, answer_idx=1, level stays 3, win=0, score unchanged.
4. Enter INPUT, no punch for 10 cycles -> loose=1; repeat with a correct punch on the expiry cycle -> no lose, answer_idx increments.
5. Punch during FLASH and start_pulse during INPUT -> no state change and seg_in_ans unchanged; start_pulse with auth_bit=0 -> stays IDLE.
6. logout mid-FLASH -> next cycle IDLE, flash_valid=0, level=1, score=0; separately, rst low mid-INPUT -> all outputs at reset values immediately.

Source files
------------

// File: rtl/memory_game_core_if.sv
// Player/display bus for the memory-game core: player controls in, display and status out.
interface memory_game_core_if #(
    parameter int unsigned DIGIT_W = 4,
    parameter int unsigned MAX_LEN = 8
) ();
    logic                           auth_bit;
    logic                           logout;
    logic                           start_pulse;
    logic                           punch_button;
    logic [DIGIT_W-1:0]             toggle_answer;
    logic [DIGIT_W-1:0]             flash_num;
    logic                           flash_valid;
    logic [DIGIT_W-1:0]             seg_in_ans;
    logic [$clog2(MAX_LEN)-1:0]     answer_idx;
    logic [$clog2(MAX_LEN+1)-1:0]   level;
    logic [7:0]                     score;
    logic                           win;
    logic                           loose;
    logic                           game_done;
    logic                           busy;

    // Driven by the authentication/debounce side.
    modport master (
        output auth_bit, logout, start_pulse, punch_button, toggle_answer,
        input  flash_num, flash_valid, seg_in_ans, answer_idx, level, score,
        input  win, loose, game_done, busy
    );

    // Implemented by the game core.
    modport slave (
        input  auth_bit, logout, start_pulse, punch_button, toggle_answer,
        output flash_num, flash_valid, seg_in_ans, answer_idx, level, score,
        output win, loose, game_done, busy
    );
endinterface

// File: rtl/memory_game_core.sv
// Memory-game engine: generates an LFSR digit sequence, flashes it, then scores player answers.
module memory_game_core #(
    parameter int unsigned DIGIT_W        = 4,
    parameter int unsigned MAX_LEN        = 8,
    parameter int unsigned FLASH_CYCLES   = 50000000,
    parameter int unsigned GAP_CYCLES     = 12500000,
    parameter int unsigned ANSWER_TIMEOUT = 250000000,
    parameter logic [15:0] LFSR_SEED      = 16'hACE1
) (
    input logic               clock,
    input logic               rst,
    memory_game_core_if.slave game_io
);
    localparam int unsigned IdxW = $clog2(MAX_LEN);
    localparam int unsigned LvlW = $clog2(MAX_LEN + 1);

    typedef enum logic [2:0] {
        StIdle, StGen, StFlash, StGap, StInput, StWin, StLose
    } state_e;

    state_e             state_q, state_d;
    logic [15:0]        lfsr_q;
    logic [DIGIT_W-1:0] seq_q [MAX_LEN];
    logic               seq_we;
    logic [IdxW-1:0]    idx_q, idx_d;
    logic [IdxW-1:0]    ans_idx_q, ans_idx_d;
    logic [31:0]        cnt_q, cnt_d;
    logic [LvlW-1:0]    level_q, level_d;
    logic [7:0]         score_q, score_d;
    logic               win_q, win_d;
    logic               loose_q, loose_d;
    logic               done_q, done_d;
    logic [DIGIT_W-1:0] seg_q, seg_d;
    logic               last_idx, last_ans, match;

    assign last_idx = (LvlW'(idx_q) == level_q - LvlW'(1));
    assign last_ans = (LvlW'(ans_idx_q) == level_q - LvlW'(1));
    assign match    = (game_io.toggle_answer == seq_q[ans_idx_q]);

    // Free-running Fibonacci LFSR (taps 16,14,13,11), right-shifting.
    always_ff @(posedge clock or negedge rst) begin
        if (!rst) begin
            lfsr_q <= LFSR_SEED;
        end else begin
            lfsr_q <= {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[15:1]};
        end
    end

    // Sequence storage, filled one digit per GEN cycle.
    always_ff @(posedge clock or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < int'(MAX_LEN); i++) begin
                seq_q[i] <= '0;
            end
        end else if (seq_we) begin
            seq_q[idx_q] <= lfsr_q[DIGIT_W-1:0];
        end
    end

    // State and datapath registers.
    always_ff @(posedge clock or negedge rst) begin
        if (!rst) begin
            state_q   <= StIdle;
            idx_q     <= '0;
            ans_idx_q <= '0;
            cnt_q     <= '0;
            level_q   <= LvlW'(1);
            score_q   <= '0;
            win_q     <= 1'b0;
            loose_q   <= 1'b0;
            done_q    <= 1'b0;
            seg_q     <= '0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            ans_idx_q <= ans_idx_d;
            cnt_q     <= cnt_d;
            level_q   <= level_d;
            score_q   <= score_d;
            win_q     <= win_d;
            loose_q   <= loose_d;
            done_q    <= done_d;
            seg_q     <= seg_d;
        end
    end

    // Next-state logic; cnt_q is the flash/gap timer and doubles as the answer timeout.
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        ans_idx_d = ans_idx_q;
        cnt_d     = cnt_q;
        level_d   = level_q;
        score_d   = score_q;
        win_d     = win_q;
        loose_d   = loose_q;
        done_d    = done_q;
        seg_d     = seg_q;
        seq_we    = 1'b0;
        if (game_io.logout) begin
            state_d   = StIdle;
            level_d   = LvlW'(1);
            score_d   = '0;
            win_d     = 1'b0;
            loose_d   = 1'b0;
            done_d    = 1'b0;
            seg_d     = '0;
            ans_idx_d = '0;
            idx_d     = '0;
            cnt_d     = '0;
        end else begin
            unique case (state_q)
                StIdle, StWin, StLose: begin
                    if (game_io.start_pulse && game_io.auth_bit) begin
                        state_d   = StGen;
                        win_d     = 1'b0;
                        loose_d   = 1'b0;
                        ans_idx_d = '0;
                        seg_d     = '0;
                        idx_d     = '0;
                        cnt_d     = '0;
                        // A finished game restarts from the shortest sequence.
                        if (done_q) begin
                            level_d = LvlW'(1);
                            done_d  = 1'b0;
                        end
                    end
                end
                StGen: begin
                    seq_we = 1'b1;
                    if (last_idx) begin
                        state_d = StFlash;
                        idx_d   = '0;
                        cnt_d   = '0;
                    end else begin
                        idx_d = idx_q + IdxW'(1);
                    end
                end
                StFlash: begin
                    if (cnt_q == FLASH_CYCLES - 1) begin
                        state_d = StGap;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 32'd1;
                    end
                end
                StGap: begin
                    if (cnt_q == GAP_CYCLES - 1) begin
                        cnt_d = '0;
                        if (last_idx) begin
                            state_d   = StInput;
                            ans_idx_d = '0;
                        end else begin
                            state_d = StFlash;
                            idx_d   = idx_q + IdxW'(1);
                        end
                    end else begin
                        cnt_d = cnt_q + 32'd1;
                    end
                end
                StInput: begin
                    // A punch on the expiry cycle wins over the timeout.
                    if (game_io.punch_button) begin
                        seg_d = game_io.toggle_answer;
                        cnt_d = '0;
                        if (!match) begin
                            state_d = StLose;
                            loose_d = 1'b1;
                        end else if (last_ans) begin
                            state_d = StWin;
                            win_d   = 1'b1;
                            if (score_q != 8'hFF) begin
                                score_d = score_q + 8'd1;
                            end
                            if (level_q < LvlW'(MAX_LEN)) begin
                                level_d = level_q + LvlW'(1);
                            end else begin
                                done_d = 1'b1;
                            end
                        end else begin
                            ans_idx_d = ans_idx_q + IdxW'(1);
                        end
                    end else if (cnt_q == ANSWER_TIMEOUT - 1) begin
                        state_d = StLose;
                        loose_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 32'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Outputs; the flashed digit is blanked outside FLASH.
    always_comb begin
        game_io.flash_valid = (state_q == StFlash);
        game_io.flash_num   = (state_q == StFlash) ? seq_q[idx_q] : '0;
        game_io.seg_in_ans  = seg_q;
        game_io.answer_idx  = ans_idx_q;
        game_io.level       = level_q;
        game_io.score       = score_q;
        game_io.win         = win_q;
        game_io.loose       = loose_q;
        game_io.game_done   = done_q;
        game_io.busy        = !(state_q inside {StIdle, StWin, StLose});
    end
endmodule

// File: tb/tb_memory_game_core.sv
// Bench for memory_game_core: directed rounds, LFSR reference model, queued expectations.
module tb_memory_game_core;
    localparam int unsigned DW = 4;
    localparam int unsigned ML = 4;
    localparam int unsigned FC = 4;
    localparam int unsigned GC = 2;
    localparam int unsigned AT = 10;

    typedef struct packed {
        logic       win;
        logic       loose;
        logic [2:0] level;
        logic [7:0] score;
        logic       done;
        logic [1:0] idx;
        logic [3:0] seg;
    } outcome_t;

    logic clock = 1'b0;
    logic rst   = 1'b0;
    always #5 clock = ~clock;

    memory_game_core_if #(.DIGIT_W(DW), .MAX_LEN(ML)) bus_if ();

    memory_game_core #(
        .DIGIT_W       (DW),
        .MAX_LEN       (ML),
        .FLASH_CYCLES  (FC),
        .GAP_CYCLES    (GC),
        .ANSWER_TIMEOUT(AT),
        .LFSR_SEED     (16'hACE1)
    ) dut (
        .clock  (clock),
        .rst    (rst),
        .game_io(bus_if)
    );

    int errors = 0;
    int checks = 0;

    // Reference LFSR, same reset and clocking as the design.
    logic [15:0] m_lfsr;
    always @(posedge clock or negedge rst) begin
        if (!rst) m_lfsr <= 16'hACE1;
        else      m_lfsr <= {m_lfsr[0] ^ m_lfsr[2] ^ m_lfsr[3] ^ m_lfsr[5], m_lfsr[15:1]};
    end

    logic [3:0] flash_q [$];
    outcome_t   out_q [$];
    logic [3:0] exp_seq [ML];
    int         exp_level = 1;
    int         exp_score = 0;
    bit         exp_done  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: pops expectations when a digit starts flashing or a round result appears.
    logic prev_fv  = 1'b0;
    logic prev_end = 1'b0;
    always @(negedge clock) begin
        outcome_t o_act;
        outcome_t o_exp;
        logic [3:0] d_exp;
        if (rst) begin
            if (bus_if.flash_valid && !prev_fv) begin
                if (flash_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL flash_unexpected: got digit %0h expected none", bus_if.flash_num);
                end else begin
                    d_exp = flash_q.pop_front();
                    check("flash_num", 32'(bus_if.flash_num), 32'(d_exp));
                end
            end
            if ((bus_if.win || bus_if.loose) && !prev_end) begin
                o_act.win   = bus_if.win;
                o_act.loose = bus_if.loose;
                o_act.level = bus_if.level;
                o_act.score = bus_if.score;
                o_act.done  = bus_if.game_done;
                o_act.idx   = bus_if.answer_idx;
                o_act.seg   = bus_if.seg_in_ans;
                if (out_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL outcome_unexpected: got %0h expected none", o_act);
                end else begin
                    o_exp = out_q.pop_front();
                    check("outcome", 32'(o_act), 32'(o_exp));
                end
            end
            check("win_loose_excl", 32'(bus_if.win & bus_if.loose), 32'd0);
        end
        prev_fv  <= bus_if.flash_valid;
        prev_end <= bus_if.win | bus_if.loose;
    end

    task automatic tick();
        @(negedge clock);
    endtask

    task automatic push_outcome(input bit w, input int idx, input logic [3:0] seg);
        outcome_t o;
        o.win   = w;
        o.loose = !w;
        o.level = 3'(exp_level);
        o.score = 8'(exp_score);
        o.done  = exp_done;
        o.idx   = 2'(idx);
        o.seg   = seg;
        out_q.push_back(o);
    endtask

    // Start a round and record the digits the GEN cycles will latch.
    task automatic do_start();
        bus_if.auth_bit    = 1'b1;
        bus_if.start_pulse = 1'b1;
        tick();
        bus_if.start_pulse = 1'b0;
        if (exp_done) begin
            exp_level = 1;
            exp_done  = 0;
        end
        check("gen_busy", 32'(bus_if.busy), 32'd1);
        check("gen_clear_win", 32'(bus_if.win | bus_if.loose), 32'd0);
        check("gen_no_flash", 32'(bus_if.flash_valid), 32'd0);
        for (int i = 0; i < exp_level; i++) begin
            exp_seq[i] = m_lfsr[3:0];
            flash_q.push_back(m_lfsr[3:0]);
            tick();
        end
    endtask

    task automatic do_flash(input bit punch_in_flash);
        for (int d = 0; d < exp_level; d++) begin
            for (int c = 0; c < int'(FC); c++) begin
                check("flash_hi", 32'(bus_if.flash_valid), 32'd1);
                check("flash_busy", 32'(bus_if.busy), 32'd1);
                if (punch_in_flash && d == 0 && c == 0) begin
                    bus_if.toggle_answer = 4'hF;
                    bus_if.punch_button  = 1'b1;
                end else begin
                    bus_if.punch_button = 1'b0;
                end
                tick();
            end
            for (int c = 0; c < int'(GC); c++) begin
                check("gap_lo", 32'(bus_if.flash_valid), 32'd0);
                check("gap_num0", 32'(bus_if.flash_num), 32'd0);
                check("gap_busy", 32'(bus_if.busy), 32'd1);
                tick();
            end
        end
        check("input_idx0", 32'(bus_if.answer_idx), 32'd0);
        check("input_seg0", 32'(bus_if.seg_in_ans), 32'd0);
    endtask

    task automatic punch(input logic [3:0] v);
        bus_if.toggle_answer = v;
        bus_if.punch_button  = 1'b1;
        tick();
        bus_if.punch_button  = 1'b0;
        check("seg_echo", 32'(bus_if.seg_in_ans), 32'(v));
    endtask

    // Answer correctly from start_j to the end of the sequence.
    task automatic play_from(input int start_j);
        int lvl;
        lvl = exp_level;
        for (int j = start_j; j < lvl; j++) begin
            if (j == lvl - 1) begin
                if (exp_score < 255) exp_score++;
                if (exp_level < int'(ML)) exp_level++;
                else exp_done = 1;
                push_outcome(1'b1, j, exp_seq[j]);
            end
            punch(exp_seq[j]);
            if (j < lvl - 1) check("ans_idx_inc", 32'(bus_if.answer_idx), 32'(j + 1));
        end
        check("win_idle", 32'(bus_if.busy), 32'd0);
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_busy"}, 32'(bus_if.busy), 32'd0);
        check({tag, "_level"}, 32'(bus_if.level), 32'd1);
        check({tag, "_score"}, 32'(bus_if.score), 32'd0);
        check({tag, "_flags"},
              32'({bus_if.win, bus_if.loose, bus_if.game_done, bus_if.flash_valid}), 32'd0);
        check({tag, "_idx_seg"}, 32'({bus_if.answer_idx, bus_if.seg_in_ans, bus_if.flash_num}),
              32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus_if.auth_bit      = 1'b0;
        bus_if.logout        = 1'b0;
        bus_if.start_pulse   = 1'b0;
        bus_if.punch_button  = 1'b0;
        bus_if.toggle_answer = '0;
        tick();
        tick();
        check_reset_vals("reset");
        rst = 1'b1;

        // Levels 1..4, all correct.
        for (int r = 0; r < 4; r++) begin
            do_start();
            do_flash(1'b0);
            play_from(0);
        end
        check("final_done", 32'(bus_if.game_done), 32'd1);
        check("final_level", 32'(bus_if.level), 32'd4);
        check("final_score", 32'(bus_if.score), 32'd4);

        // Climb back to level 3, then miss the second answer.
        for (int r = 0; r < 2; r++) begin
            do_start();
            do_flash(1'b0);
            play_from(0);
        end
        check("level3", 32'(bus_if.level), 32'd3);
        do_start();
        do_flash(1'b0);
        punch(exp_seq[0]);
        check("lose_idx1", 32'(bus_if.answer_idx), 32'd1);
        push_outcome(1'b0, 1, exp_seq[1] ^ 4'h1);
        punch(exp_seq[1] ^ 4'h1);
        check("lose_win0", 32'(bus_if.win), 32'd0);
        check("lose_level", 32'(bus_if.level), 32'd3);
        check("lose_score", 32'(bus_if.score), 32'd6);

        // Timeout with no punch.
        do_start();
        do_flash(1'b0);
        for (int k = 0; k < int'(AT) - 1; k++) tick();
        check("tmo_not_yet", 32'(bus_if.loose), 32'd0);
        push_outcome(1'b0, 0, 4'h0);
        tick();
        check("tmo_loose", 32'(bus_if.loose), 32'd1);

        // Punch on the expiry cycle is evaluated instead of timing out.
        do_start();
        do_flash(1'b0);
        for (int k = 0; k < int'(AT) - 1; k++) tick();
        play_from(0);
        check("tmo_punch_level", 32'(bus_if.level), 32'd4);

        // Punch during FLASH and start during INPUT are ignored.
        do_start();
        do_flash(1'b1);
        bus_if.start_pulse = 1'b1;
        tick();
        bus_if.start_pulse = 1'b0;
        check("start_in_input_busy", 32'(bus_if.busy), 32'd1);
        check("start_in_input_idx", 32'(bus_if.answer_idx), 32'd0);
        play_from(0);
        check("done_again", 32'(bus_if.game_done), 32'd1);
        check("score8", 32'(bus_if.score), 32'd8);

        // Start without authentication.
        bus_if.auth_bit    = 1'b0;
        bus_if.start_pulse = 1'b1;
        tick();
        bus_if.start_pulse = 1'b0;
        check("noauth_win_held", 32'(bus_if.win), 32'd1);
        check("noauth_busy", 32'(bus_if.busy), 32'd0);

        // Logout in the middle of FLASH.
        do_start();
        check("flash_before_logout", 32'(bus_if.flash_valid), 32'd1);
        tick();
        bus_if.logout = 1'b1;
        tick();
        bus_if.logout = 1'b0;
        exp_level = 1;
        exp_score = 0;
        exp_done  = 0;
        check_reset_vals("logout");

        // Unauthenticated start from IDLE.
        bus_if.auth_bit    = 1'b0;
        bus_if.start_pulse = 1'b1;
        tick();
        bus_if.start_pulse = 1'b0;
        check("noauth_idle", 32'(bus_if.busy), 32'd0);
        tick();
        check("noauth_idle2", 32'(bus_if.flash_valid), 32'd0);

        // Win level 1, then reset mid-INPUT of level 2.
        do_start();
        do_flash(1'b0);
        play_from(0);
        check("post_logout_score", 32'(bus_if.score), 32'd1);
        do_start();
        do_flash(1'b0);
        punch(exp_seq[0]);
        check("pre_rst_idx", 32'(bus_if.answer_idx), 32'd1);
        #2;
        rst = 1'b0;
        #1;
        exp_level = 1;
        exp_score = 0;
        check_reset_vals("midrst");
        tick();
        rst = 1'b1;
        tick();
        check_reset_vals("after_rst");

        check("flash_q_empty", 32'(flash_q.size()), 32'd0);
        check("out_q_empty", 32'(out_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
